comparador_sequencial: RTL and testbench
========================================

COMPARADOR_SEQUENCIAL -- requirements
Module: comparador_sequencial

Interface
REQ-001 SHALL take parameter DIGIT_W, default 4, giving the bit width of one code digit.
REQ-002 SHALL take parameter N_DIGITS, default 4, giving the number of digits per code (range 1..16).
REQ-003 SHALL take parameter MAX_TRIES, default 3, giving the failed attempts allowed before lockout (range 1..15).
REQ-004 SHALL take parameter TIMEOUT_CYCLES, default 1000, giving the inter-digit timeout (used only under REQ-027).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: block active; low aborts entry and parks in IDLE.
REQ-008 SHALL have port code_in, input, N_DIGITS*DIGIT_W bits: secret code, with digit 0 in the LSBs.
REQ-009 SHALL have port digit_in, input, DIGIT_W bits: entered digit.
REQ-010 SHALL have port digit_valid, input, 1 bit: one-cycle strobe; digit_in is valid on that cycle.
REQ-011 SHALL have port clear, input, 1 bit: synchronous return from MATCH to IDLE; it never clears LOCKED.
REQ-012 SHALL have port match, output, 1 bit: one-cycle pulse on a correct code.
REQ-013 SHALL have port fail, output, 1 bit: one-cycle pulse on a wrong code or timeout.
REQ-014 SHALL have port ok, output, 1 bit: level, high while in MATCH.
REQ-015 SHALL have port locked, output, 1 bit: level, high while in LOCKED.
REQ-016 SHALL have port tries_left, output, $clog2(MAX_TRIES+1) bits: remaining attempts.
REQ-017 SHALL have port digit_idx, output, $clog2(N_DIGITS+1) bits: digits accepted so far in the current entry.

Function
REQ-018 SHALL implement the states IDLE, COLLECT, MATCH and LOCKED.
REQ-019 SHALL, in IDLE with enable=1 and digit_valid=1, latch code_in into an internal code register, compare digit 0, set digit_idx=1 and go to COLLECT.
REQ-020 SHALL, in COLLECT, compare each accepted digit k against latched slice k and OR any inequality into a sticky err flag; digits are never rejected early.
REQ-021 SHALL, on the cycle after the N_DIGITS-th digit is accepted:
- if err=0: pulse match, enter MATCH and reload tries_left to MAX_TRIES;
- if err=1: pulse fail and decrement tries_left; enter LOCKED if the new value is 0, else IDLE;
- in every case zero digit_idx and err.
REQ-022 SHALL ignore digit_valid in MATCH and LOCKED; MATCH leaves only via clear=1 (to IDLE) or reset.
REQ-023 SHALL, when enable=0 in COLLECT, go to IDLE the next cycle with digit_idx=0 and err=0, without consuming an attempt and without pulsing fail.
REQ-024 SHALL give clear priority over digit_valid in the same cycle; clear in IDLE or COLLECT aborts the entry as in REQ-023.
REQ-025 SHALL treat N_DIGITS=1 as accept-then-resolve on the next cycle, with no special case.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force:
- state=IDLE;
- match=0, fail=0, ok=0, locked=0;
- digit_idx=0, err=0;
- tries_left=MAX_TRIES;
- code register=0.
Reset mid-entry discards the partial entry.

Configuration
REQ-027 SHALL, with CODE_TIMEOUT_EN defined, run a counter in COLLECT that restarts on every accepted digit; reaching TIMEOUT_CYCLES with no digit resolves the entry as err=1 per REQ-021.
REQ-028 SHALL, without CODE_TIMEOUT_EN, contain no timeout counter; COLLECT waits indefinitely and TIMEOUT_CYCLES is unused.

Structure
REQ-029 SHALL take the state enum type and the default parameter constants from package comparador_pkg.
REQ-030 SHALL instantiate sub-module comparador_digito (parametrised DIGIT_W, combinational equality of two digits) for the per-digit compare.

Verification
REQ-031 Bench SHALL cover the following directed scenarios:
- Correct code: code_in=16'h1234, digits 4,3,2,1 -> match pulses 1 cycle after the last digit, ok=1, tries_left=3.
- Wrong code: code_in=16'h1234, digits 4,3,9,1 -> fail pulse, state IDLE, tries_left=2; the third digit does not abort early.
- Lockout: three wrong entries -> locked=1, tries_left=0; a further correct entry is ignored; clear is ignored; only rst_n=0 restores tries_left=3.
- Abort: two digits, then enable=0 -> digit_idx=0, no fail, tries_left unchanged; a following correct entry matches.
- Clear priority: in MATCH, clear=1 with digit_valid=1 -> IDLE next cycle, ok=0, digit not counted.
- Timeout (CODE_TIMEOUT_EN, TIMEOUT_CYCLES=10): one digit then 10 idle cycles -> fail pulse, tries_left decrements.

Source files
------------

// File: rtl/comparador_pkg.sv
// rtl/comparador_pkg.sv - state type and default parameters for the sequential code comparator
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    MATCH   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int DEF_DIGIT_W        = 4;
  localparam int DEF_N_DIGITS       = 4;
  localparam int DEF_MAX_TRIES      = 3;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/comparador_digito.sv
// rtl/comparador_digito.sv - combinational equality of one entered digit against one code digit
module comparador_digito #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output logic               eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparador_sequencial.sv
// rtl/comparador_sequencial.sv - digit-serial code entry checker with retry limit and lockout
// Optional inter-digit timeout is built only when CODE_TIMEOUT_EN is defined.
module comparador_sequencial
  import comparador_pkg::*;
#(
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int N_DIGITS       = DEF_N_DIGITS,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [N_DIGITS*DIGIT_W-1:0]         code_in,
  input  logic [DIGIT_W-1:0]                  digit_in,
  input  logic                                digit_valid,
  input  logic                                clear,
  output logic                                match,
  output logic                                fail,
  output logic                                ok,
  output logic                                locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left,
  output logic [$clog2(N_DIGITS+1)-1:0]       digit_idx
);

  localparam int TRW  = $clog2(MAX_TRIES+1);
  localparam int IDXW = $clog2(N_DIGITS+1);

  state_t                        state_q;
  logic [N_DIGITS*DIGIT_W-1:0]   code_q;
  logic [IDXW-1:0]               idx_q;
  logic [TRW-1:0]                tries_q;
  logic                          err_q;
  logic                          match_q;
  logic                          fail_q;
  logic                          ok_q;
  logic                          locked_q;

  logic [DIGIT_W-1:0]            ref_digit;
  logic                          digit_eq;
  logic                          full_c;
  logic                          resolve_c;
  logic                          err_c;

  // The first digit is checked against the live code_in, since the latch happens on that same edge.
  always_comb begin
    ref_digit = code_q[DIGIT_W-1:0];
    if (state_q == IDLE) begin
      ref_digit = code_in[DIGIT_W-1:0];
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IDXW'(i)) ref_digit = code_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  comparador_digito #(.DIGIT_W(DIGIT_W)) u_digito (
    .a_i  (digit_in),
    .b_i  (ref_digit),
    .eq_o (digit_eq)
  );

  assign full_c = (idx_q == IDXW'(N_DIGITS));

`ifdef CODE_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYCLES+1);
  logic [TMW-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q != COLLECT || digit_valid) begin
      tmo_q <= '0;
    end else if (tmo_q != TMW'(TIMEOUT_CYCLES-1)) begin
      tmo_q <= tmo_q + TMW'(1);
    end
  end

  // A timeout resolves a partial entry, which is always treated as wrong.
  assign resolve_c = full_c || (!digit_valid && tmo_q == TMW'(TIMEOUT_CYCLES-1));
  assign err_c     = err_q || !full_c;
`else
  assign resolve_c = full_c;
  assign err_c     = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      tries_q  <= TRW'(MAX_TRIES);
      err_q    <= 1'b0;
      match_q  <= 1'b0;
      fail_q   <= 1'b0;
      ok_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && !clear && digit_valid) begin
            code_q  <= code_in;
            err_q   <= !digit_eq;
            idx_q   <= IDXW'(1);
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (!enable || clear) begin
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end else if (resolve_c) begin
            idx_q <= '0;
            err_q <= 1'b0;
            if (!err_c) begin
              match_q <= 1'b1;
              ok_q    <= 1'b1;
              tries_q <= TRW'(MAX_TRIES);
              state_q <= MATCH;
            end else begin
              fail_q  <= 1'b1;
              tries_q <= tries_q - TRW'(1);
              if (tries_q == TRW'(1)) begin
                locked_q <= 1'b1;
                state_q  <= LOCKED;
              end else begin
                state_q <= IDLE;
              end
            end
          end else if (digit_valid) begin
            err_q <= err_q | !digit_eq;
            idx_q <= idx_q + IDXW'(1);
          end
        end
        MATCH: begin
          if (clear) begin
            ok_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign match      = match_q;
  assign fail       = fail_q;
  assign ok         = ok_q;
  assign locked     = locked_q;
  assign tries_left = tries_q;
  assign digit_idx  = idx_q;

endmodule

// File: tb/tb_comparador_sequencial.sv
// tb/tb_comparador_sequencial.sv - self-checking bench for comparador_sequencial
module tb_comparador_sequencial;

  localparam int DW = 4;
  localparam int ND = 4;
  localparam int MT = 3;
  localparam int TO = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b1;
  logic [ND*DW-1:0]     code_in = 16'h1234;
  logic [DW-1:0]        digit_in = '0;
  logic                 digit_valid = 1'b0;
  logic                 clear = 1'b0;
  logic                 match, fail, ok, locked;
  logic [1:0]           tries_left;
  logic [2:0]           digit_idx;

  int checks = 0;
  int failures = 0;

  comparador_sequencial #(
    .DIGIT_W(DW), .N_DIGITS(ND), .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .code_in(code_in),
    .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
    .match(match), .fail(fail), .ok(ok), .locked(locked),
    .tries_left(tries_left), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the entered digits and judges the whole entry when it resolves.
  int          m_q[$];
  logic [15:0] m_code = '0;
  bit          m_col = 0, m_ok = 0, m_lock = 0, m_match = 0, m_fail = 0;
  int          m_tries = MT;
  int          m_idle = 0;

  always @(posedge clk or negedge rst_n) begin
    bit good;
    bit tmo;
    if (!rst_n) begin
      m_q.delete();
      m_col = 0; m_ok = 0; m_lock = 0; m_match = 0; m_fail = 0;
      m_tries = MT; m_idle = 0; m_code = '0;
    end else begin
      m_match = 0;
      m_fail = 0;
`ifdef CODE_TIMEOUT_EN
      tmo = !digit_valid && (m_idle == TO-1);
`else
      tmo = 0;
`endif
      if (m_lock) begin
      end else if (m_ok) begin
        if (clear) m_ok = 0;
      end else if (!m_col) begin
        if (enable && !clear && digit_valid) begin
          m_code = code_in;
          m_q.delete();
          m_q.push_back(int'(digit_in));
          m_col = 1;
          m_idle = 0;
        end
      end else if (!enable || clear) begin
        m_q.delete();
        m_col = 0;
      end else if (m_q.size() == ND || tmo) begin
        good = (m_q.size() == ND);
        for (int k = 0; k < m_q.size(); k++)
          if (m_q[k] != int'(m_code[k*DW +: DW])) good = 0;
        if (good) begin
          m_match = 1; m_ok = 1; m_tries = MT;
        end else begin
          m_fail = 1; m_tries = m_tries - 1;
          if (m_tries == 0) m_lock = 1;
        end
        m_q.delete();
        m_col = 0;
      end else if (digit_valid) begin
        m_q.push_back(int'(digit_in));
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("match", int'(match), int'(m_match));
    check("fail", int'(fail), int'(m_fail));
    check("ok", int'(ok), int'(m_ok));
    check("locked", int'(locked), int'(m_lock));
    check("tries_left", int'(tries_left), m_tries);
    check("digit_idx", int'(digit_idx), m_q.size());
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int d);
    digit_valid = 1'b1;
    digit_in = DW'(d);
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic entry(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  function automatic logic [DW-1:0] good_digit();
    if (m_col && m_q.size() < ND) return m_code[m_q.size()*DW +: DW];
    return code_in[DW-1:0];
  endfunction

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_match", int'(match), 0);
    check("rst_ok", int'(ok), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_tries", int'(tries_left), 3);
    check("rst_idx", int'(digit_idx), 0);

    entry(4, 3, 2, 1);
    check("full_idx", int'(digit_idx), 4);
    check("match_early", int'(match), 0);
    tick();
    check("match_pulse", int'(match), 1);
    check("ok_set", int'(ok), 1);
    check("tries_match", int'(tries_left), 3);
    tick();
    check("match_one_cycle", int'(match), 0);
    check("ok_level", int'(ok), 1);

    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd4;
    tick();
    clear = 1'b0; digit_valid = 1'b0;
    check("clear_ok", int'(ok), 0);
    check("clear_idx", int'(digit_idx), 0);

    send(4); send(3); send(9);
    check("no_early_abort", int'(digit_idx), 3);
    check("no_early_fail", int'(fail), 0);
    send(1);
    tick();
    check("fail_pulse", int'(fail), 1);
    check("tries_wrong", int'(tries_left), 2);
    check("idx_wrong", int'(digit_idx), 0);

    send(4); send(3);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("abort_idx", int'(digit_idx), 0);
    check("abort_fail", int'(fail), 0);
    check("abort_tries", int'(tries_left), 2);
    entry(4, 3, 2, 1);
    tick();
    check("after_abort_match", int'(match), 1);
    check("after_abort_tries", int'(tries_left), 3);
    clear = 1'b1; tick(); clear = 1'b0;

    for (int n = 0; n < 3; n++) begin
      entry(0, 0, 0, 0);
      tick();
    end
    check("lock_locked", int'(locked), 1);
    check("lock_tries", int'(tries_left), 0);
    entry(4, 3, 2, 1);
    tick();
    check("lock_ignore_match", int'(match), 0);
    check("lock_ignore_idx", int'(digit_idx), 0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("lock_ignore_clear", int'(locked), 1);
    rst_n = 1'b0;
    #1;
    check("reset_tries", int'(tries_left), 3);
    check("reset_unlock", int'(locked), 0);
    tick();
    rst_n = 1'b1;

`ifdef CODE_TIMEOUT_EN
    send(4);
    repeat (9) tick();
    check("tmo_not_yet", int'(fail), 0);
    check("tmo_idx", int'(digit_idx), 1);
    tick();
    check("tmo_fail", int'(fail), 1);
    check("tmo_tries", int'(tries_left), 2);
`endif

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      enable = ($urandom_range(0, 15) != 0);
      clear = ($urandom_range(0, 31) == 0);
      digit_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) code_in = 16'($urandom);
      if ($urandom_range(0, 3) != 0) digit_in = good_digit();
      else digit_in = 4'($urandom);
      tick();
    end
    digit_valid = 1'b0; clear = 1'b0; enable = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
